// File: rtl/distance_pkg.sv
// Shared types and helpers for the squared-Euclidean / Manhattan distance engine.
package distance_pkg;

  typedef enum logic {
    DIST_L2 = 1'b0,
    DIST_L1 = 1'b1
  } dist_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Wide enough for NUM_PIX worst-case squared differences without overflow.
  function automatic int acc_width(input int pix_w, input int num_pix);
    return 2 * pix_w + $clog2(num_pix);
  endfunction

endpackage

// File: rtl/distance_lane_term.sv
// One lane of the distance datapath: absolute difference, optionally squared.
module lane_term
  import distance_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0]   known,
  input  logic [PIX_W-1:0]   unknown,
  input  dist_mode_e         mode,
  output logic [2*PIX_W-1:0] term
);

  logic [PIX_W-1:0]   diff_s;
  logic [2*PIX_W-1:0] diff_ext_s;

  // Unsigned |known - unknown|, then L1 passes it through and L2 squares it.
  always_comb begin
    diff_s     = {PIX_W{1'b0}};
    diff_ext_s = {(2*PIX_W){1'b0}};
    term       = {(2*PIX_W){1'b0}};
    if (known >= unknown) begin
      diff_s = known - unknown;
    end else begin
      diff_s = unknown - known;
    end
    diff_ext_s = {{PIX_W{1'b0}}, diff_s};
    if (mode == DIST_L1) begin
      term = diff_ext_s;
    end else begin
      term = diff_ext_s * diff_ext_s;
    end
  end

endmodule

// File: rtl/distance_engine.sv
// Streams an image pair LANES pixels per beat and accumulates L1 or L2 distance,
// presenting the total on a valid/ready result port.
module distance_engine
  import distance_pkg::*;
#(
  parameter  int PIX_W   = 8,
  parameter  int LANES   = 4,
  parameter  int NUM_PIX = 784,
  localparam int ACC_W   = acc_width(PIX_W, NUM_PIX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] in_known,
  input  logic [LANES*PIX_W-1:0] in_unknown,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_dist,
  output logic                   out_len_err,
  output logic                   busy
);

  localparam int BEATS  = NUM_PIX / LANES;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int TERM_W = 2 * PIX_W;
  localparam int LSUM_W = TERM_W + $clog2(LANES);

  if (NUM_PIX % LANES != 0) begin : g_bad_num_pix
    $error("distance_engine: NUM_PIX must be a multiple of LANES");
  end

  state_e             state_r;
  state_e             state_s;
  dist_mode_e         mode_r;
  dist_mode_e         lane_mode_s;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               accept_s;
  logic               term_s;
  logic               len_err_s;
  logic               handshake_s;
  logic [TERM_W-1:0]  lane_term_s [LANES];
  logic [LSUM_W-1:0]  lane_sum_s;
  logic [LSUM_W-1:0]  sum_r;
  logic               s1_valid_r;
  logic [ACC_W-1:0]   acc_r;
  logic               len_err_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_dist    = acc_r;
  assign out_len_err = len_err_r;
  assign busy        = busy_r;

  assign accept_s    = in_valid && in_ready_r;
  assign handshake_s = out_valid_r && out_ready;

  // Beat bookkeeping; the first beat uses the live mode pin since mode_r is not latched yet.
  always_comb begin
    cnt_next_s  = {CNT_W{1'b0}};
    lane_mode_s = DIST_L2;
    if (state_r == IDLE) begin
      cnt_next_s  = CNT_W'(1'b1);
      lane_mode_s = dist_mode_e'(mode);
    end else begin
      cnt_next_s  = beat_cnt_r + CNT_W'(1'b1);
      lane_mode_s = mode_r;
    end
    term_s    = in_last || (cnt_next_s == CNT_W'(BEATS));
    len_err_s = in_last ^ (cnt_next_s == CNT_W'(BEATS));
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_term #(.PIX_W(PIX_W)) u_lane_term (
      .known   (in_known[g*PIX_W +: PIX_W]),
      .unknown (in_unknown[g*PIX_W +: PIX_W]),
      .mode    (lane_mode_s),
      .term    (lane_term_s[g])
    );
  end

  // Sum of all lane terms for the beat currently presented.
  always_comb begin
    lane_sum_s = {LSUM_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lane_sum_s = lane_sum_s + LSUM_W'(lane_term_s[i]);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = term_s ? DRAIN : ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && term_s) begin
          state_s = DRAIN;
        end else begin
          state_s = ACCUM;
        end
      end
      DRAIN: begin
        if (s1_valid_r) begin
          state_s = HOLD;
        end else begin
          state_s = DRAIN;
        end
      end
      HOLD: begin
        if (handshake_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, registered handshake/status flags, beat counter and length error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      mode_r      <= DIST_L2;
      beat_cnt_r  <= {CNT_W{1'b0}};
      len_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE) || (state_s == ACCUM);
      out_valid_r <= (state_s == HOLD);
      busy_r      <= (state_s != IDLE);
      if (accept_s) begin
        beat_cnt_r <= cnt_next_s;
        if (state_r == IDLE) begin
          mode_r <= dist_mode_e'(mode);
        end
        if (term_s) begin
          len_err_r <= len_err_s;
        end
      end else if (handshake_s) begin
        beat_cnt_r <= {CNT_W{1'b0}};
        len_err_r  <= 1'b0;
      end
    end
  end

  // Two-stage datapath: register the beat sum, then fold it into the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      sum_r      <= {LSUM_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        sum_r <= lane_sum_s;
      end
      if (s1_valid_r) begin
        acc_r <= acc_r + ACC_W'(sum_r);
      end else if (handshake_s) begin
        acc_r <= {ACC_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_distance_engine.sv
// Directed, table-driven bench for distance_engine with hand-computed results.
module tb_distance_engine;
  localparam int PIX_W   = 8;
  localparam int LANES   = 4;
  localparam int NUM_PIX = 784;
  localparam int ACC_W   = 2 * PIX_W + $clog2(NUM_PIX);
  localparam int DW      = LANES * PIX_W;

  logic              clk = 1'b0;
  logic              reset, mode, in_valid, in_last, out_ready;
  logic [DW-1:0]     in_known, in_unknown;
  logic              in_ready, out_valid, out_len_err, busy;
  logic [ACC_W-1:0]  out_dist;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          md;
    logic [DW-1:0] kv;
    logic [DW-1:0] uv;
    int            nbeats;
    int            last_beat;
    bit            gaps;
    int            toggle_at;
    longint        exp_dist;
    bit            exp_err;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  distance_engine #(.PIX_W(PIX_W), .LANES(LANES), .NUM_PIX(NUM_PIX)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_known(in_known), .in_unknown(in_unknown), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
    .out_len_err(out_len_err), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present beats until nbeats are accepted; counts cycles where in_ready was low.
  task automatic feed(input int id, input vec_t v);
    int  accepted = 0;
    int  drops    = 0;
    int  guard    = 0;
    bit  vv, will;
    while (accepted < v.nbeats && guard < 3000) begin
      vv         = v.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid   = vv;
      in_known   = v.kv;
      in_unknown = v.uv;
      in_last    = (v.last_beat != 0) && (accepted + 1 == v.last_beat);
      mode       = (v.toggle_at != 0 && accepted >= v.toggle_at) ? ~v.md : v.md;
      if (!in_ready) drops++;
      will = vv && in_ready;
      step();
      if (will) accepted++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check($sformatf("v%0d_beats_accepted", id), accepted, v.nbeats);
    check($sformatf("v%0d_ready_during_accum", id), drops, 0);
  endtask

  // Called right after the terminating beat's edge: checks drain, latency, result, handshake.
  task automatic finish_vec(input int id, input longint exp_dist, input bit exp_err, input int hold);
    int lat = 1;
    check($sformatf("v%0d_drain_valid_ready", id), {out_valid, in_ready}, 2'b00);
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check($sformatf("v%0d_latency", id), lat, 2);
    check($sformatf("v%0d_dist", id), out_dist, exp_dist);
    check($sformatf("v%0d_len_err", id), out_len_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      in_valid   = 1'b1;
      in_known   = {DW{1'b0}};
      in_unknown = {DW{1'b1}};
      step();
      check($sformatf("v%0d_hold%0d_valid_ready", id, i), {out_valid, in_ready}, 2'b10);
      check($sformatf("v%0d_hold%0d_dist", id, i), out_dist, exp_dist);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check($sformatf("v%0d_after_handshake", id), {out_valid, busy, in_ready}, 3'b001);
  endtask

  initial begin
    vec_t v;
    // mode, known, unknown, beats, last_beat, gaps, toggle_at, exp_dist, exp_err
    tbl[0] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 196, 196, 1'b0, 0,   64'd50979600, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 196, 196, 1'b0, 100, 64'd199920,   1'b0};
    tbl[2] = '{1'b0, 32'h2525_2525, 32'h2525_2525, 196, 196, 1'b1, 0,   64'd0,        1'b0};
    tbl[3] = '{1'b0, 32'h0A0A_0A0A, 32'h0909_0909, 11,  11,  1'b0, 0,   64'd44,       1'b1};
    tbl[4] = '{1'b0, 32'h0A0A_0A0A, 32'h0909_0909, 196, 0,   1'b0, 0,   64'd784,      1'b1};
    tbl[5] = '{1'b1, 32'h0303_0303, 32'hC8C8_C8C8, 196, 196, 1'b0, 0,   64'd154448,   1'b0};
    tbl[6] = '{1'b0, 32'h281E_140A, 32'h001E_0F0D, 196, 196, 1'b0, 0,   64'd320264,   1'b0};

    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_known = {DW{1'b0}}; in_unknown = {DW{1'b0}};
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_state", {out_valid, out_len_err, busy, in_ready}, 4'b0001);
    check("reset_dist", out_dist, 0);

    for (int i = 0; i < 7; i++) begin
      feed(i, tbl[i]);
      finish_vec(i, tbl[i].exp_dist, tbl[i].exp_err, 0);
      step();
    end

    // Result backpressure with in_valid held high, then a fresh vector with no carry-over.
    out_ready = 1'b0;
    feed(10, tbl[0]);
    finish_vec(10, tbl[0].exp_dist, 1'b0, 5);
    v = tbl[4];
    v.last_beat = 196;
    feed(11, v);
    finish_vec(11, 784, 1'b0, 0);

    // Reset in the middle of a vector, then a full vector afterwards.
    v = tbl[0];
    v.nbeats = 50;
    v.last_beat = 0;
    feed(12, v);
    check("mid_vector_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("post_reset_state", {busy, out_valid, in_ready}, 3'b001);
    check("post_reset_dist", out_dist, 0);
    feed(13, tbl[0]);
    finish_vec(13, tbl[0].exp_dist, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
